// File: rtl/uart_cmd_sched.sv
// uart_cmd_sched: round-robin scheduler sharing one UART byte channel
// among N_REQ command sources; read commands wait for one reply byte.
module uart_cmd_sched #(
  parameter int N_REQ     = 2,
  parameter int CMD_WIDTH = 16,
  parameter int TIMEOUT   = 5000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_vld,
  input  logic [N_REQ*CMD_WIDTH-1:0] req_cmd,
  output logic [N_REQ-1:0]           req_rdy,
  output logic [N_REQ-1:0]           rsp_vld,
  output logic [7:0]                 rsp_data,
  output logic                       rsp_err,
  output logic [7:0]                 tx_data,
  output logic                       tx_vld,
  input  logic                       tx_rdy,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_vld,
  output logic                       busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [PW:0] NR = (PW+1)'(N_REQ);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SEND_HI,
    SEND_LO,
    WAIT_RSP
  } state_t;

  state_t state;
  state_t state_n;

  logic [CMD_WIDTH-1:0] cmd_q;
  logic [CMD_WIDTH-1:0] cmd_sel;
  logic [PW-1:0]        gnt_q;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        rr_n;
  logic [PW-1:0]        off;
  logic [PW-1:0]        win;
  logic [PW:0]          sum;
  logic [PW:0]          nxt;
  logic [N_REQ-1:0]     rot;
  logic [N_REQ-1:0]     gnt_hot;
  logic [TW-1:0]        timer;
  logic                 found;
  logic                 accept;
  logic                 to_wait;
  logic                 rsp_ok;
  logic                 rsp_to;

  // Rotate so bit 0 is the requester at rr_ptr; first set bit wins.
  assign rot = N_REQ'({req_vld, req_vld} >> rr_ptr);

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = PW'(k);
      end
    end
  end

  assign sum = {1'b0, rr_ptr} + {1'b0, off};
  assign win = (sum >= NR) ? PW'(sum - NR) : sum[PW-1:0];
  assign nxt = {1'b0, win} + (PW+1)'(1);
  assign rr_n = (nxt >= NR) ? '0 : nxt[PW-1:0];

  assign accept = (state == IDLE) && found && !rst;
  assign busy   = (state != IDLE);

  always_comb begin
    req_rdy = '0;
    gnt_hot = '0;
    cmd_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_rdy[i] = accept && (win == PW'(i));
      gnt_hot[i] = (gnt_q == PW'(i));
      if (win == PW'(i)) begin
        cmd_sel = req_cmd[i*CMD_WIDTH +: CMD_WIDTH];
      end
    end
  end

  always_comb begin
    state_n = state;
    tx_vld  = 1'b0;
    tx_data = '0;
    to_wait = 1'b0;
    rsp_ok  = 1'b0;
    rsp_to  = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n = SEND_HI;
        end
      end
      SEND_HI: begin
        tx_vld  = 1'b1;
        tx_data = cmd_q[15:8];
        if (tx_rdy) begin
          state_n = SEND_LO;
        end
      end
      SEND_LO: begin
        tx_vld  = 1'b1;
        tx_data = cmd_q[7:0];
        if (tx_rdy) begin
          if (cmd_q[CMD_WIDTH-1]) begin
            to_wait = 1'b1;
            state_n = WAIT_RSP;
          end else begin
            state_n = IDLE;
          end
        end
      end
      WAIT_RSP: begin
        // A byte arriving on the last cycle still beats the timeout.
        if (rx_vld) begin
          rsp_ok  = 1'b1;
          state_n = IDLE;
        end else if (timer == T_LAST) begin
          rsp_to  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      gnt_q    <= '0;
      cmd_q    <= '0;
      timer    <= '0;
      rsp_vld  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      state   <= state_n;
      rsp_vld <= '0;
      if (accept) begin
        cmd_q  <= cmd_sel;
        gnt_q  <= win;
        rr_ptr <= rr_n;
      end
      if (to_wait) begin
        timer <= '0;
      end else if (state == WAIT_RSP && timer != T_LAST) begin
        timer <= timer + TW'(1);
      end
      if (rsp_ok || rsp_to) begin
        rsp_vld  <= gnt_hot;
        rsp_data <= rsp_ok ? rx_data : 8'hFF;
        rsp_err  <= rsp_to;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_sched.sv
// tb_uart_cmd_sched: table of directed transactions plus hand-written
// reset, back-to-back and stray-byte sequences.
module tb_uart_cmd_sched;

  logic        clk;
  logic        rst;
  logic [1:0]  req_vld;
  logic [31:0] req_cmd;
  logic [1:0]  req_rdy;
  logic [1:0]  rsp_vld;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [7:0]  tx_data;
  logic        tx_vld;
  logic        tx_rdy;
  logic [7:0]  rx_data;
  logic        rx_vld;
  logic        busy;

  int n_cmp;
  int n_bad;
  int cycles;

  logic [7:0] last_data;
  logic       last_err;

  uart_cmd_sched #(
    .N_REQ(2),
    .CMD_WIDTH(16),
    .TIMEOUT(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_vld(req_vld),
    .req_cmd(req_cmd),
    .req_rdy(req_rdy),
    .rsp_vld(rsp_vld),
    .rsp_data(rsp_data),
    .rsp_err(rsp_err),
    .tx_data(tx_data),
    .tx_vld(tx_vld),
    .tx_rdy(tx_rdy),
    .rx_data(rx_data),
    .rx_vld(rx_vld),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cycles <= cycles + 1;
    if (cycles > 20000) begin
      $display("FAIL watchdog: got %0d cycles, limit 20000", cycles);
      $fatal(1, "watchdog expired");
    end
  end

  typedef struct {
    logic [1:0]  vld;
    logic [15:0] cmd0;
    logic [15:0] cmd1;
    int          stall;
    int          g;
    logic [7:0]  hi;
    logic [7:0]  lo;
    bit          rd;
    int          dly;
    bit          rx_en;
    logic [7:0]  rx_byte;
    logic [7:0]  e_data;
    bit          e_err;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0] hot;
    hot = 2'b01 << v.g;
    tx_rdy  = 1'b0;
    req_vld = v.vld;
    req_cmd = {v.cmd1, v.cmd0};
    @(negedge clk);
    check($sformatf("v%0d req_rdy", idx), 32'(req_rdy), 32'(hot));
    step();
    req_vld = 2'b00;
    req_cmd = 32'hDEAD_BEEF;
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      check($sformatf("v%0d hold_hi", idx),
            {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, v.hi});
      step();
    end
    tx_rdy = 1'b1;
    @(negedge clk);
    check($sformatf("v%0d tx_hi", idx),
          {22'd0, busy, tx_vld, tx_data}, {22'd0, 2'b11, v.hi});
    step();
    @(negedge clk);
    check($sformatf("v%0d tx_lo", idx),
          {22'd0, busy, tx_vld, tx_data}, {22'd0, 2'b11, v.lo});
    step();
    tx_rdy = 1'b0;
    if (!v.rd) begin
      @(negedge clk);
      check($sformatf("v%0d wr_done", idx),
            {21'd0, busy, rsp_vld, rsp_data},
            {21'd0, 1'b0, 2'b00, last_data});
      step();
    end else begin
      for (int c = 0; c < v.dly; c++) begin
        @(negedge clk);
        check($sformatf("v%0d wait_quiet", idx),
              {28'd0, busy, tx_vld, rsp_vld}, {28'd0, 1'b1, 1'b0, 2'b00});
        step();
      end
      if (v.rx_en) begin
        rx_vld  = 1'b1;
        rx_data = v.rx_byte;
        step();
        rx_vld  = 1'b0;
        rx_data = 8'h00;
      end
      @(negedge clk);
      check($sformatf("v%0d rsp", idx),
            {20'd0, busy, rsp_vld, rsp_err, rsp_data},
            {20'd0, 1'b0, hot, v.e_err, v.e_data});
      last_data = v.e_data;
      last_err  = v.e_err;
      step();
      @(negedge clk);
      check($sformatf("v%0d rsp_clear", idx),
            {21'd0, rsp_vld, rsp_err, rsp_data},
            {21'd0, 2'b00, last_err, last_data});
      step();
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_bad   = 0;
    cycles  = 0;
    rst     = 1'b1;
    req_vld = 2'b11;
    req_cmd = 32'h1234_5678;
    tx_rdy  = 1'b0;
    rx_data = 8'h00;
    rx_vld  = 1'b0;
    last_data = 8'h00;
    last_err  = 1'b0;

    tbl[0] = '{2'b01, 16'h1234, 16'h0000, 0, 0, 8'h12, 8'h34,
               0, 0, 0, 8'h00, 8'h00, 0};
    tbl[1] = '{2'b11, 16'h1111, 16'h2222, 0, 1, 8'h22, 8'h22,
               0, 0, 0, 8'h00, 8'h00, 0};
    tbl[2] = '{2'b11, 16'h3333, 16'h4444, 0, 0, 8'h33, 8'h33,
               0, 0, 0, 8'h00, 8'h00, 0};
    tbl[3] = '{2'b11, 16'h5555, 16'h6666, 0, 1, 8'h66, 8'h66,
               0, 0, 0, 8'h00, 8'h00, 0};
    tbl[4] = '{2'b01, 16'h8A05, 16'h0000, 0, 0, 8'h8A, 8'h05,
               1, 10, 1, 8'h5C, 8'h5C, 0};
    tbl[5] = '{2'b01, 16'h1234, 16'h0000, 7, 0, 8'h12, 8'h34,
               0, 0, 0, 8'h00, 8'h00, 0};
    tbl[6] = '{2'b10, 16'h0000, 16'h9ABC, 0, 1, 8'h9A, 8'hBC,
               1, 16, 0, 8'h00, 8'hFF, 1};
    tbl[7] = '{2'b11, 16'hC0DE, 16'h0001, 0, 0, 8'hC0, 8'hDE,
               1, 15, 1, 8'hA7, 8'hA7, 0};
    tbl[8] = '{2'b01, 16'h0055, 16'h0000, 2, 0, 8'h00, 8'h55,
               0, 0, 0, 8'h00, 8'h00, 0};
    tbl[9] = '{2'b10, 16'h0000, 16'h8001, 0, 1, 8'h80, 8'h01,
               1, 0, 1, 8'h3C, 8'h3C, 0};

    step();
    @(negedge clk);
    check("rst_rdy", 32'(req_rdy), 32'd0);
    step();
    rst     = 1'b0;
    req_vld = 2'b00;
    @(negedge clk);
    check("rst_vals",
          {12'd0, busy, tx_vld, tx_data, rsp_vld, rsp_err, rsp_data},
          32'd0);
    step();

    for (int i = 0; i < 10; i++) begin
      run_vec(i, tbl[i]);
    end

    // Back-to-back: second accept in the first IDLE cycle.
    req_vld = 2'b01;
    req_cmd = {16'h0000, 16'h0102};
    tx_rdy  = 1'b1;
    @(negedge clk);
    check("b2b_rdy0", 32'(req_rdy), 32'd1);
    step();
    @(negedge clk);
    check("b2b_hi", 32'(tx_data), 32'h01);
    step();
    @(negedge clk);
    check("b2b_lo", 32'(tx_data), 32'h02);
    step();
    @(negedge clk);
    check("b2b_rdy1", {30'd0, busy, req_rdy[0]}, {30'd0, 2'b01});
    req_vld = 2'b00;
    tx_rdy  = 1'b0;
    step();

    // Reset during SEND_LO; rr_ptr must return to 0.
    req_vld = 2'b01;
    req_cmd = {16'h0000, 16'h0A0B};
    step();
    req_vld = 2'b00;
    tx_rdy  = 1'b1;
    step();
    @(negedge clk);
    check("lo_before_rst", {23'd0, tx_vld, tx_data}, {23'd0, 1'b1, 8'h0B});
    rst    = 1'b1;
    tx_rdy = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_lo", {28'd0, busy, tx_vld, rsp_vld}, 32'd0);
    req_vld = 2'b11;
    #1;
    check("rr_after_rst_lo", 32'(req_rdy), 32'd1);
    req_vld = 2'b00;
    step();

    // Reset during WAIT_RSP with a coincident rx byte.
    req_vld = 2'b01;
    req_cmd = {16'h0000, 16'h8123};
    step();
    req_vld = 2'b00;
    tx_rdy  = 1'b1;
    step();
    step();
    tx_rdy = 1'b0;
    step();
    step();
    @(negedge clk);
    check("in_wait", {30'd0, busy, tx_vld}, {30'd0, 2'b10});
    step();
    rst     = 1'b1;
    rx_vld  = 1'b1;
    rx_data = 8'h99;
    step();
    rst    = 1'b0;
    rx_vld = 1'b0;
    @(negedge clk);
    check("rst_wait",
          {20'd0, busy, tx_vld, rsp_vld, rsp_data}, 32'd0);
    step();
    rx_vld  = 1'b1;
    rx_data = 8'h77;
    step();
    rx_vld = 1'b0;
    @(negedge clk);
    check("stray_rx",
          {21'd0, busy, rsp_vld, rsp_data}, 32'd0);
    req_vld = 2'b11;
    #1;
    check("rr_after_rst_wait", 32'(req_rdy), 32'd1);
    req_vld = 2'b00;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
